// File: rtl/accelerator_write_strength_scheduler_pkg.sv
// Shared definitions for the DNC accelerator write-strength scheduler.
//   sched_state_e : scheduler FSM encoding (also driven out on DEBUG_STATE)
//   DEFAULT_HEADS : default number of write-head requesters
//   params_ok     : legal-configuration predicate for the scheduler
package accelerator_write_strength_scheduler_pkg;

    localparam int DEFAULT_HEADS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    function automatic bit params_ok(input int heads, input int data_size, input int control_size);
        return (heads >= 2) && (heads <= 16) && (data_size > 0) && (control_size > 0);
    endfunction

endpackage

// File: rtl/accelerator_round_robin_arbiter.sv
// Round-robin arbiter: picks the first set request bit searching upward
// from last_grant+1, wrapping modulo HEADS.
//   req        in  HEADS          request vector
//   last_grant in  $clog2(HEADS)  most recently granted index
//   grant      out $clog2(HEADS)  selected index (0 when valid is low)
//   valid      out 1              at least one request is set
module accelerator_round_robin_arbiter #(
    parameter int HEADS = 4
) (
    input  logic [HEADS-1:0]         req,
    input  logic [$clog2(HEADS)-1:0] last_grant,
    output logic [$clog2(HEADS)-1:0] grant,
    output logic                     valid
);

    localparam int GW = $clog2(HEADS);

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= HEADS; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= HEADS) begin
                idx = idx - HEADS;
            end
            if (!valid && req[GW'(idx)]) begin
                valid = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/accelerator_write_strength_scheduler.sv
// Shares one scalar oneplus unit between HEADS write heads. Each head posts
// a beta word with a START pulse; requests are served one at a time in
// round-robin order and the registered result appears on that head's
// BETA_OUT slice together with a one-cycle READY pulse.
//
// Ports:
//   CLK, RST           clock (rising edge) and synchronous active-low reset
//   START[h]           request pulse for head h, BETA_IN slice h captured with it
//   READY[h]           one-cycle completion pulse for head h (one-hot or zero)
//   BETA_OUT           per-head registered oneplus results
//   OVERRUN[h]         sticky: a START on head h was dropped
//   BUSY               a request is pending or in service
//   ONEPLUS_START      one-cycle issue strobe to the oneplus unit
//   ONEPLUS_DATA_IN    operand, held through ISSUE and WAIT, zero in IDLE
//   ONEPLUS_READY      completion strobe from the unit, used only in WAIT
//   ONEPLUS_DATA_OUT   unit result, valid with ONEPLUS_READY
//   DEBUG_STATE        current FSM state
//
// Handshake: a head request is accepted only when the head has nothing
// pending and is not in service; otherwise it is dropped and flagged on
// OVERRUN. Towards the unit, ONEPLUS_START is a single-cycle pulse and the
// operation ends on the first ONEPLUS_READY seen while in WAIT.
module accelerator_write_strength_scheduler
    import accelerator_write_strength_scheduler_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int HEADS        = DEFAULT_HEADS
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [HEADS-1:0]           START,
    input  logic [HEADS*DATA_SIZE-1:0] BETA_IN,
    output logic [HEADS-1:0]           READY,
    output logic [HEADS*DATA_SIZE-1:0] BETA_OUT,
    output logic [HEADS-1:0]           OVERRUN,
    output logic                       BUSY,
    output logic                       ONEPLUS_START,
    output logic [DATA_SIZE-1:0]       ONEPLUS_DATA_IN,
    input  logic                       ONEPLUS_READY,
    input  logic [DATA_SIZE-1:0]       ONEPLUS_DATA_OUT,
    output sched_state_e               DEBUG_STATE
);

    localparam int GW = $clog2(HEADS);

    // CONTROL_SIZE belongs to the oneplus unit wired up by the parent; here it
    // only takes part in the configuration legality check.
    if (params_ok(HEADS, DATA_SIZE, CONTROL_SIZE)) begin : g_sched

        sched_state_e           state, state_next;
        logic [HEADS-1:0]       pending;
        logic [HEADS-1:0]       in_service;
        logic [DATA_SIZE-1:0]   beta_q [HEADS];
        logic [HEADS*DATA_SIZE-1:0] beta_out_q;
        logic [HEADS-1:0]       ready_q;
        logic [HEADS-1:0]       overrun_q;
        logic [GW-1:0]          grant_q;
        logic [GW-1:0]          last_grant_q;
        logic [GW-1:0]          arb_grant;
        logic                   arb_valid;
        logic                   complete;
        logic                   op_start;
        logic [DATA_SIZE-1:0]   op_data;

        accelerator_round_robin_arbiter #(
            .HEADS (HEADS)
        ) u_arbiter (
            .req        (pending),
            .last_grant (last_grant_q),
            .grant      (arb_grant),
            .valid      (arb_valid)
        );

        // The granted head stays "in service" from ISSUE until it returns to
        // IDLE, which also covers a START arriving alongside ONEPLUS_READY.
        always_comb begin
            in_service = '0;
            if (state != ST_IDLE) begin
                in_service[grant_q] = 1'b1;
            end
        end

        always_comb begin
            state_next = state;
            op_start   = 1'b0;
            op_data    = '0;
            complete   = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    op_start   = 1'b1;
                    op_data    = beta_q[grant_q];
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    op_data = beta_q[grant_q];
                    if (ONEPLUS_READY) begin
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (!RST) begin
                state        <= ST_IDLE;
                pending      <= '0;
                beta_q       <= '{default: '0};
                beta_out_q   <= '0;
                ready_q      <= '0;
                overrun_q    <= '0;
                grant_q      <= '0;
                last_grant_q <= GW'(HEADS - 1);
            end else begin
                state   <= state_next;
                ready_q <= '0;
                if (state == ST_IDLE && arb_valid) begin
                    grant_q <= arb_grant;
                end
                if (complete) begin
                    beta_out_q[grant_q*DATA_SIZE +: DATA_SIZE] <= ONEPLUS_DATA_OUT;
                    pending[grant_q] <= 1'b0;
                    last_grant_q     <= grant_q;
                    ready_q[grant_q] <= 1'b1;
                end
                // The completing head is in service, so its pending bit is
                // never set here in the same cycle it is cleared above.
                for (int h = 0; h < HEADS; h++) begin
                    if (START[h]) begin
                        if (pending[h] || in_service[h]) begin
                            overrun_q[h] <= 1'b1;
                        end else begin
                            pending[h] <= 1'b1;
                            beta_q[h]  <= BETA_IN[h*DATA_SIZE +: DATA_SIZE];
                        end
                    end
                end
            end
        end

        assign READY           = ready_q;
        assign BETA_OUT        = beta_out_q;
        assign OVERRUN         = overrun_q;
        assign BUSY            = (|pending) || (state != ST_IDLE);
        assign ONEPLUS_START   = op_start;
        assign ONEPLUS_DATA_IN = op_data;
        assign DEBUG_STATE     = state;

    end else begin : g_illegal_config
        // Unsupported configuration: the block stays inert.
        assign READY           = '0;
        assign BETA_OUT        = '0;
        assign OVERRUN         = '0;
        assign BUSY            = 1'b0;
        assign ONEPLUS_START   = 1'b0;
        assign ONEPLUS_DATA_IN = '0;
        assign DEBUG_STATE     = ST_IDLE;
    end

endmodule

// File: tb/tb_accelerator_write_strength_scheduler.sv
module tb_accelerator_write_strength_scheduler;
    import accelerator_write_strength_scheduler_pkg::*;

    localparam int DW = 64;
    localparam int NH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NH-1:0]    start = '0;
    logic [NH*DW-1:0] beta_in = '0;
    logic [NH-1:0]    ready;
    logic [NH*DW-1:0] beta_out;
    logic [NH-1:0]    overrun;
    logic             busy;
    logic             op_start;
    logic [DW-1:0]    op_data_in;
    logic             op_ready;
    logic [DW-1:0]    op_data_out;
    sched_state_e     dbg_state;

    accelerator_write_strength_scheduler #(
        .DATA_SIZE    (DW),
        .CONTROL_SIZE (64),
        .HEADS        (NH)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .START            (start),
        .BETA_IN          (beta_in),
        .READY            (ready),
        .BETA_OUT         (beta_out),
        .OVERRUN          (overrun),
        .BUSY             (busy),
        .ONEPLUS_START    (op_start),
        .ONEPLUS_DATA_IN  (op_data_in),
        .ONEPLUS_READY    (op_ready),
        .ONEPLUS_DATA_OUT (op_data_out),
        .DEBUG_STATE      (dbg_state)
    );

    // ---------------- oneplus unit model (latency 3 after start) ----------------
    function automatic logic [DW-1:0] oneplus_model(input logic [DW-1:0] x);
        return x * 64'd3 + 64'd1;
    endfunction

    logic          m_busy = 1'b0;
    logic [1:0]    m_cnt = '0;
    logic [DW-1:0] m_data = '0;
    logic          force_ready = 1'b0;
    logic [DW-1:0] force_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (op_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 2'd2;
            m_data <= op_data_in;
        end else if (m_busy) begin
            if (m_cnt == 2'd0) m_busy <= 1'b0;
            else               m_cnt  <= m_cnt - 2'd1;
        end
    end

    assign op_ready    = (m_busy && m_cnt == 2'd0) || force_ready;
    assign op_data_out = force_ready ? force_data : oneplus_model(m_data);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [NH-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // READY order monitor: every pulse must match the head expected next.
    always @(negedge clk) begin
        if (op_start) start_cnt++;
        if (ready !== '0) begin
            if (exp_q.size() == 0) begin
                check("ready_unexpected", DW'(ready), '0);
            end else begin
                check("ready_order", DW'(ready), DW'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [DW-1:0] slice_of(input int h);
        return beta_out[h*DW +: DW];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 64'd1, 64'd0);
        tick();
    endtask

    task automatic drive_beta(input int h, input logic [DW-1:0] b);
        beta_in[h*DW +: DW] = b;
    endtask

    // Single request into an idle block, with cycle-exact latency checks.
    task automatic run_single(input int h, input logic [DW-1:0] b, input logic [DW-1:0] exp_out);
        logic [NH-1:0] mask;
        mask = NH'(1) << h;
        exp_q.push_back(mask);
        start = mask;
        drive_beta(h, b);
        tick();                                   // t+1
        start = '0;
        check("single_start_t1", DW'(op_start), 64'd0);
        check("single_busy_t1", DW'(busy), 64'd1);
        tick();                                   // t+2
        check("single_start_t2", DW'(op_start), 64'd1);
        check("single_data_in", op_data_in, b);
        tick(); tick(); tick();                   // t+5
        check("single_ready_t5", DW'(ready), 64'd0);
        tick();                                   // t+6
        check("single_ready_t6", DW'(ready), DW'(mask));
        check("single_beta_out", slice_of(h), exp_out);
        check("single_busy_t6", DW'(busy), 64'd0);
        tick();                                   // t+7
        check("single_ready_t7", DW'(ready), 64'd0);
    endtask

    typedef struct {
        int            head;
        logic [DW-1:0] beta;
        logic [DW-1:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        vecs[0] = '{2, 64'd5,             64'd16};
        vecs[1] = '{0, 64'd0,             64'd1};
        vecs[2] = '{1, 64'd10,            64'd31};
        vecs[3] = '{3, 64'h100,           64'h301};
        vecs[4] = '{2, 64'h0000_FFFF_FFFF, 64'h2_FFFF_FFFE};

        // Reset state
        do_reset();
        tick();
        check("rst_ready", DW'(ready), 64'd0);
        check("rst_overrun", DW'(overrun), 64'd0);
        check("rst_busy", DW'(busy), 64'd0);
        check("rst_op_start", DW'(op_start), 64'd0);
        check("rst_op_data", op_data_in, 64'd0);
        check("rst_beta_out", beta_out[DW-1:0] | beta_out[2*DW +: DW], 64'd0);
        check("rst_state", DW'(dbg_state), DW'(ST_IDLE));

        // Table of single requests
        for (int i = 0; i < 5; i++) begin
            run_single(vecs[i].head, vecs[i].beta, vecs[i].exp_out);
        end
        check("table_overrun", DW'(overrun), 64'd0);

        // All four heads in one cycle, from reset: order 0,1,2,3
        do_reset();
        s0 = start_cnt;
        for (int h = 0; h < NH; h++) begin
            drive_beta(h, DW'(20 + h));
            exp_q.push_back(NH'(1) << h);
        end
        start = '1;
        tick();
        start = '0;
        wait_idle("all4");
        check("all4_start_pulses", DW'(start_cnt - s0), 64'd4);
        check("all4_queue_empty", DW'(exp_q.size()), 64'd0);
        for (int h = 0; h < NH; h++) begin
            check("all4_beta_out", slice_of(h), oneplus_model(DW'(20 + h)));
        end

        // last_grant=1 after head 1 completes: 0011 serves head 0 then head 1
        run_single(1, 64'd7, 64'd22);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        drive_beta(0, 64'd2);
        drive_beta(1, 64'd3);
        start = 4'b0011;
        tick();
        start = '0;
        wait_idle("rr01");
        check("rr01_queue_empty", DW'(exp_q.size()), 64'd0);
        check("rr01_beta0", slice_of(0), 64'd7);
        check("rr01_beta1", slice_of(1), 64'd10);

        // Repeated START[3] while pending: overrun, one op, first beta kept
        do_reset();
        s0 = start_cnt;
        exp_q.push_back(4'b1000);
        start = 4'b1000;
        drive_beta(3, 64'd7);
        tick();
        drive_beta(3, 64'd9);
        tick();
        start = '0;
        check("ovr_data_in", op_data_in, 64'd7);
        wait_idle("ovr");
        check("ovr_flag", DW'(overrun), 64'h8);
        check("ovr_one_op", DW'(start_cnt - s0), 64'd1);
        check("ovr_beta3", slice_of(3), 64'd22);
        tick();
        check("ovr_sticky", DW'(overrun), 64'h8);

        // START on the completing head in the ONEPLUS_READY cycle is dropped
        do_reset();
        s0 = start_cnt;
        exp_q.push_back(4'b0001);
        start = 4'b0001;
        drive_beta(0, 64'd4);
        tick();                                   // t+1
        start = '0;
        tick(); tick(); tick(); tick();           // t+5
        check("coll_op_ready", DW'(op_ready), 64'd1);
        start = 4'b0001;
        drive_beta(0, 64'd99);
        tick();                                   // t+6
        start = '0;
        check("coll_ready", DW'(ready), 64'h1);
        check("coll_overrun", DW'(overrun), 64'h1);
        check("coll_busy", DW'(busy), 64'd0);
        check("coll_beta0", slice_of(0), 64'd13);
        tick(); tick();
        check("coll_one_op", DW'(start_cnt - s0), 64'd1);

        // Reset during WAIT abandons the operation
        run_single(1, 64'd10, 64'd31);
        start = 4'b0100;
        drive_beta(2, 64'd8);
        tick();                                   // t+1
        start = '0;
        tick(); tick();                           // t+3 (WAIT)
        check("rstw_in_wait", DW'(dbg_state), DW'(ST_WAIT));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rstw_state", DW'(dbg_state), DW'(ST_IDLE));
        check("rstw_ready", DW'(ready), 64'd0);
        check("rstw_beta_out1", slice_of(1), 64'd0);
        check("rstw_overrun", DW'(overrun), 64'd0);
        check("rstw_busy", DW'(busy), 64'd0);
        check("rstw_op_start", DW'(op_start), 64'd0);
        check("rstw_op_data", op_data_in, 64'd0);
        tick(); tick(); tick(); tick();
        run_single(0, 64'd6, 64'd19);

        // ONEPLUS_READY while IDLE is ignored
        force_data = 64'hDEAD;
        force_ready = 1'b1;
        tick();
        force_ready = 1'b0;
        tick();
        check("idle_rdy_beta0", slice_of(0), 64'd19);
        check("idle_rdy_state", DW'(dbg_state), DW'(ST_IDLE));
        check("idle_rdy_busy", DW'(busy), 64'd0);
        tick();

        check("final_queue_empty", DW'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
